// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: captures exception/interrupt/mret at IDU handover and commits
// single-cycle CSR writes plus an IFU redirect at LSU retire. Define TRAP_IRQ_EN for interrupts.
module trap_ctrl #(
    parameter int unsigned XLEN    = 32,  // CPU_WIDTH
    parameter int unsigned NUM_IRQ = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_idu_valid,
    input  logic               i_lsu_valid,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_dnpc,
    input  logic [XLEN-1:0]    i_instr,
    input  logic               i_ecall,
    input  logic               i_ebreak,
    input  logic               i_illegal,
    input  logic               i_mret,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_mie,
    input  logic [XLEN-1:0]    i_mstatus,
    input  logic [XLEN-1:0]    i_mtvec,
    input  logic [XLEN-1:0]    i_mepc,
    output logic               o_mepc_wen,
    output logic [XLEN-1:0]    o_mepc_wdata,
    output logic               o_mcause_wen,
    output logic [XLEN-1:0]    o_mcause_wdata,
    output logic               o_mtval_wen,
    output logic [XLEN-1:0]    o_mtval_wdata,
    output logic               o_mstatus_wen,
    output logic [XLEN-1:0]    o_mstatus_wdata,
    output logic               o_redirect,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic               o_busy
);

    typedef enum logic [0:0] {StIdle, StHeld} state_e;
    typedef enum logic [1:0] {EvNone, EvExc, EvIrq, EvMret} event_e;

    state_e state_q, state_d;
    event_e ev_q, ev_d;
    logic [4:0]      code_q, code_d;
    logic [XLEN-1:0] pc_q, dnpc_q, instr_q, mstatus_q, mtvec_q, mepc_q;

    logic            commit;
    logic [XLEN-1:0] mtval_val;
    logic [XLEN-1:0] trap_mstatus;
    logic [XLEN-1:0] mret_mstatus;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] irq_target;

    // Event resolution, highest priority first
    always_comb begin
        ev_d   = EvNone;
        code_d = 5'd0;
        if (i_illegal) begin
            ev_d   = EvExc;
            code_d = 5'd2;
        end else if (i_ebreak) begin
            ev_d   = EvExc;
            code_d = 5'd3;
        end else if (i_ecall) begin
            ev_d   = EvExc;
            code_d = 5'd11;
        end else if (i_mret) begin
            ev_d = EvMret;
        end else begin
`ifdef TRAP_IRQ_EN
            // Descending scan so the lowest pending line wins
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (i_irq[i] && i_mie[i] && i_mstatus[3]) begin
                    ev_d   = EvIrq;
                    code_d = 5'(16 + i);
                end
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_idu_valid) begin
            state_d = (ev_d == EvNone) ? StIdle : StHeld;
        end else if (state_q == StHeld && i_lsu_valid) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ev_q      <= EvNone;
            code_q    <= 5'd0;
            pc_q      <= '0;
            dnpc_q    <= '0;
            instr_q   <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
        end else if (i_idu_valid) begin
            ev_q      <= ev_d;
            code_q    <= code_d;
            pc_q      <= i_pc;
            dnpc_q    <= i_dnpc;
            instr_q   <= i_instr;
            mstatus_q <= i_mstatus;
            mtvec_q   <= i_mtvec;
            mepc_q    <= i_mepc;
        end
    end

    // Reset in the commit cycle suppresses the write as well as clearing the held event
    assign commit = (state_q == StHeld) && i_lsu_valid && i_rst_n;
    assign o_busy = (state_q == StHeld);

    always_comb begin
        unique case (code_q)
            5'd2:    mtval_val = instr_q;
            5'd3:    mtval_val = pc_q;
            default: mtval_val = '0;
        endcase
    end

    always_comb begin
        trap_mstatus        = mstatus_q;
        trap_mstatus[7]     = mstatus_q[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
        mret_mstatus        = mstatus_q;
        mret_mstatus[3]     = mstatus_q[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b11;
    end

    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_IRQ_EN
    // Vectored mode only for mode 1; modes 2 and 3 fall back to direct
    assign irq_target = (mtvec_q[1:0] == 2'b01) ?
                        tvec_base + {{(XLEN-7){1'b0}}, code_q, 2'b00} : tvec_base;
`else
    logic unused_irq;
    assign unused_irq = ^{i_irq, i_mie, mtvec_q[1:0]};
    assign irq_target = tvec_base;
`endif

    always_comb begin
        o_mepc_wen      = 1'b0;
        o_mepc_wdata    = '0;
        o_mcause_wen    = 1'b0;
        o_mcause_wdata  = '0;
        o_mtval_wen     = 1'b0;
        o_mtval_wdata   = '0;
        o_mstatus_wen   = 1'b0;
        o_mstatus_wdata = '0;
        o_redirect      = 1'b0;
        o_redirect_pc   = '0;
        if (commit) begin
            case (ev_q)
                EvExc: begin
                    o_mepc_wen      = 1'b1;
                    o_mepc_wdata    = pc_q;
                    o_mcause_wen    = 1'b1;
                    o_mcause_wdata  = {1'b0, (XLEN-1)'(code_q)};
                    o_mtval_wen     = 1'b1;
                    o_mtval_wdata   = mtval_val;
                    o_mstatus_wen   = 1'b1;
                    o_mstatus_wdata = trap_mstatus;
                    o_redirect      = 1'b1;
                    o_redirect_pc   = tvec_base;
                end
                EvIrq: begin
                    // The interrupted instruction has retired, so resume after it
                    o_mepc_wen      = 1'b1;
                    o_mepc_wdata    = dnpc_q;
                    o_mcause_wen    = 1'b1;
                    o_mcause_wdata  = {1'b1, (XLEN-1)'(code_q)};
                    o_mstatus_wen   = 1'b1;
                    o_mstatus_wdata = trap_mstatus;
                    o_redirect      = 1'b1;
                    o_redirect_pc   = irq_target;
                end
                EvMret: begin
                    o_mstatus_wen   = 1'b1;
                    o_mstatus_wdata = mret_mstatus;
                    o_redirect      = 1'b1;
                    o_redirect_pc   = mepc_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
